// File: rtl/clint_mh.sv
// clint_mh: multi-hart core-local interruptor with prescaled 64-bit mtime, per-hart msip/mtimecmp, registered IRQs.
// Define CLINT_MTIME_WRITE_EN to make mtime writable; otherwise mtime writes are acked and ignored.
module clint_mh #(
    parameter int NUM_HARTS = 1,
    parameter int TICK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [23:0]          addr,
    input  logic [3:0]           wmask,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 is_valid,
    output logic                 ready,
    output logic [NUM_HARTS-1:0] msip_irq,
    output logic [NUM_HARTS-1:0] mtip_irq,
    output logic [63:0]          mtime_out
);
    localparam logic [23:0] MSIP_END = 24'(4 * NUM_HARTS);
    localparam logic [23:0] CMP_BASE = 24'h004000;
    localparam logic [23:0] CMP_END  = 24'(32'h4000 + 8 * NUM_HARTS);
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [NUM_HARTS-1:0] msip_q, msip_d;
    logic [NUM_HARTS-1:0] mtip_q, mtip_d;
    logic [63:0]          mtimecmp_q [NUM_HARTS];
    logic [63:0]          mtimecmp_d [NUM_HARTS];
    logic [63:0]          mtime_q, mtime_d;
    logic [15:0]          div_q, div_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 ready_q, ready_d;

    logic        sel_msip, sel_cmp, sel_mtl, sel_mth, do_wr, tick;
    logic [31:0] rd_val;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Gating with !ready_q keeps a held request from re-triggering in its completion cycle.
    always_comb begin
        sel_msip = (addr[1:0] == 2'b00) && (addr < MSIP_END);
        sel_cmp  = (addr[1:0] == 2'b00) && (addr >= CMP_BASE) && (addr < CMP_END);
        sel_mtl  = (addr == 24'h00BFF8);
        sel_mth  = (addr == 24'h00BFFC);
        is_valid = valid && !ready_q && (sel_msip || sel_cmp || sel_mtl || sel_mth);
        do_wr    = is_valid && (wmask != 4'b0000);
        tick     = (div_q == DIV_LAST);
    end

    always_comb begin
        rd_val = 32'h0;
        msip_d = msip_q;
        for (int h = 0; h < NUM_HARTS; h++) begin
            mtimecmp_d[h] = mtimecmp_q[h];
            mtip_d[h]     = (mtime_q >= mtimecmp_q[h]);
            if (sel_msip && (addr[6:2] == 5'(h))) begin
                rd_val = {31'b0, msip_q[h]};
                if (do_wr && wmask[0]) msip_d[h] = wdata[0];
            end
            if (sel_cmp && (addr[7:3] == 5'(h))) begin
                rd_val = addr[2] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
                if (do_wr) begin
                    if (addr[2]) mtimecmp_d[h][63:32] = merge(mtimecmp_q[h][63:32], wdata, wmask);
                    else         mtimecmp_d[h][31:0]  = merge(mtimecmp_q[h][31:0], wdata, wmask);
                end
            end
        end

        div_d   = tick ? 16'h0 : div_q + 16'h1;
        mtime_d = mtime_q + {63'b0, tick};
`ifdef CLINT_MTIME_WRITE_EN
        // A written half takes the bus value instead of the tick increment.
        if (do_wr && sel_mtl) begin
            mtime_d[31:0] = merge(mtime_q[31:0], wdata, wmask);
            div_d         = 16'h0;
        end
        if (do_wr && sel_mth) begin
            mtime_d[63:32] = merge(mtime_q[63:32], wdata, wmask);
            div_d          = 16'h0;
        end
`endif
        if (sel_mtl) rd_val = mtime_q[31:0];
        if (sel_mth) rd_val = mtime_q[63:32];

        ready_d = is_valid;
        rdata_d = is_valid ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msip_q  <= '0;
            mtip_q  <= '0;
            mtime_q <= '0;
            div_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
        end else begin
            msip_q  <= msip_d;
            mtip_q  <= mtip_d;
            mtime_q <= mtime_d;
            div_q   <= div_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= mtimecmp_d[h];
        end
    end

    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign msip_irq  = msip_q;
    assign mtip_irq  = mtip_q;
    assign mtime_out = mtime_q;
endmodule

// File: tb/tb_clint_mh.sv
// Bench for clint_mh: table-driven bus vectors with a read-data scoreboard, plus timer/handshake/reset sequences.
module tb_clint_mh;
    logic        clk = 1'b0, reset = 1'b1, valid = 1'b0;
    logic [23:0] addr = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata, rdata4;
    logic        is_valid, ready, is_valid4, ready4;
    logic [1:0]  msip_irq, mtip_irq;
    logic        msip4, mtip4;
    logic [63:0] mtime_out, mtime4;
    logic [63:0] cyc = '0;
    int          nvec = 0, nerr = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [23:0] a;
        logic [3:0]  m;
        logic [31:0] d;
        logic        mapped;
        logic        chk_rd;
        logic        use_time;
        logic [31:0] rd;
        logic        chk_ms;
        logic [1:0]  ms;
    } vec_t;
    vec_t vt[22];

    clint_mh #(.NUM_HARTS(2), .TICK_DIV(1)) dut (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wmask(wmask), .wdata(wdata),
        .rdata(rdata), .is_valid(is_valid), .ready(ready), .msip_irq(msip_irq),
        .mtip_irq(mtip_irq), .mtime_out(mtime_out));

    clint_mh #(.NUM_HARTS(1), .TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .valid(1'b0), .addr(24'h0), .wmask(4'h0), .wdata(32'h0),
        .rdata(rdata4), .is_valid(is_valid4), .ready(ready4), .msip_irq(msip4),
        .mtip_irq(mtip4), .mtime_out(mtime4));

    always #5 clk = ~clk;

    // With TICK_DIV=1, mtime equals the number of clock edges seen out of reset.
    always @(posedge clk) cyc <= reset ? 64'd0 : cyc + 64'd1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic xact(input vec_t v, input string nm);
        valid = 1'b1; addr = v.a; wmask = v.m; wdata = v.d;
        #1;
        chk({nm, " is_valid"}, 64'(is_valid), 64'(v.mapped));
        if (v.mapped && v.chk_rd) sb.push_back(v.use_time ? cyc[31:0] : v.rd);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            chk({nm, " ready"}, 64'(ready), (c == 1) ? 64'(v.mapped) : 64'd0);
            if (ready && sb.size() > 0) chk({nm, " rdata"}, 64'(rdata), 64'(sb.pop_front()));
            if (c == 1 && v.chk_ms) chk({nm, " msip_irq"}, 64'(msip_irq), 64'(v.ms));
            if (c == (v.mapped ? 1 : 2)) valid = 1'b0;
        end
    endtask

    initial begin
        vec_t        w;
        logic [31:0] tgt;
        int          t_time, t_irq, m0_bad, incs, last, badsp, badstep;
        logic [63:0] prev, exp_t;
        logic [1:0]  exp_ip;

        //           addr        wmask wdata          map  rd   time rd_exp         chkms ms
        vt[0]  = '{24'h004000, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 2'b00};
        vt[1]  = '{24'h004004, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 2'b00};
        vt[2]  = '{24'h004008, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 2'b00};
        vt[3]  = '{24'h00400C, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 2'b00};
        vt[4]  = '{24'h000000, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'b00};
        vt[5]  = '{24'h000004, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'b00};
        vt[6]  = '{24'h00BFF8, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,         1'b1, 2'b00};
        vt[7]  = '{24'h00BFFC, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'b00};
        vt[8]  = '{24'h00BFF8, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,         1'b1, 2'b00};
        vt[9]  = '{24'h000008, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00};
        vt[10] = '{24'h004010, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00};
        vt[11] = '{24'h000002, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00};
        vt[12] = '{24'h000004, 4'h1, 32'h1,        1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'b10};
        vt[13] = '{24'h000004, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 2'b10};
        vt[14] = '{24'h000004, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 2'b10};
        vt[15] = '{24'h000000, 4'hE, 32'hFFFF_FFFF,1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'b10};
        vt[16] = '{24'h000000, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'b10};
        vt[17] = '{24'h004008, 4'h3, 32'h1234_5678,1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00};
        vt[18] = '{24'h004008, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hFFFF_5678, 1'b0, 2'b00};
        vt[19] = '{24'h004008, 4'hF, 32'hFFFF_FFFF,1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00};
        vt[20] = '{24'h000004, 4'h1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'b00};
        vt[21] = '{24'h000004, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'b00};

        repeat (2) @(posedge clk);
        #1;
        chk("rst rdata", 64'(rdata), 64'd0);
        chk("rst ready", 64'(ready), 64'd0);
        chk("rst is_valid", 64'(is_valid), 64'd0);
        chk("rst msip_irq", 64'(msip_irq), 64'd0);
        chk("rst mtip_irq", 64'(mtip_irq), 64'd0);
        chk("rst mtime", mtime_out, 64'd0);
        chk("rst dut4 outs", {rdata4, is_valid4, ready4, msip4, mtip4}, 64'd0);
        chk("rst dut4 mtime", mtime4, 64'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) xact(vt[i], $sformatf("vec%0d", i));
        chk("mtip quiet after table", 64'(mtip_irq), 64'd0);

        // valid held across completion: exactly one ready, at N+1
        valid = 1'b1; addr = 24'h0; wmask = 4'h0;
        #1 chk("held is_valid N", 64'(is_valid), 64'd1);
        @(posedge clk); #1;
        chk("held ready N+1", 64'(ready), 64'd1);
        chk("held is_valid N+1", 64'(is_valid), 64'd0);
        @(posedge clk); #1;
        chk("held ready N+2", 64'(ready), 64'd0);
        valid = 1'b0;
        @(posedge clk); #1;
        chk("held ready N+3", 64'(ready), 64'd0);

        // TICK_DIV=4 prescaler on the second instance
        prev = mtime4; incs = 0; last = -1; badsp = 0; badstep = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (mtime4 != prev) begin
                incs++;
                if (mtime4 != prev + 64'd1) badstep++;
                if (last >= 0 && c - last != 4) badsp++;
                last = c;
            end
            prev = mtime4;
        end
        chk("div4 increments", 64'(incs), 64'd10);
        chk("div4 spacing errors", 64'(badsp), 64'd0);
        chk("div4 step errors", 64'(badstep), 64'd0);

        // timer interrupt on hart 1
        w = '{24'h00400C, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
        xact(w, "cmp1_hi");
        tgt = cyc[31:0] + 32'd20;
        w.a = 24'h004008; w.d = tgt;
        xact(w, "cmp1_lo");
        t_time = -1; t_irq = -1; m0_bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (mtime_out == {32'h0, tgt} && t_time < 0) t_time = c;
            if (mtip_irq[1] && t_irq < 0) t_irq = c;
            if (mtip_irq[0]) m0_bad++;
            @(posedge clk); #1;
        end
        chk("mtime reached target", 64'(t_time >= 0), 64'd1);
        chk("mtip1 rise latency", 64'(t_irq - t_time), 64'd1);
        chk("mtip0 stayed low", 64'(m0_bad), 64'd0);
        chk("mtime vs edge count", mtime_out, cyc);

        valid = 1'b1; addr = 24'h004008; wmask = 4'hF; wdata = 32'hFFFF_FFFF;
        #1 chk("cmp1 restore is_valid", 64'(is_valid), 64'd1);
        @(posedge clk); #1;
        chk("cmp1 restore ready", 64'(ready), 64'd1);
        chk("mtip1 still high N+1", 64'(mtip_irq[1]), 64'd1);
        valid = 1'b0;
        @(posedge clk); #1;
        chk("mtip1 low N+2", 64'(mtip_irq[1]), 64'd0);

        // mtime writes: wrap when writable, ignored otherwise
        w = '{24'h00BFFC, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
        xact(w, "mtime_hi_wr");
        valid = 1'b1; addr = 24'h00BFF8; wmask = 4'hF; wdata = 32'hFFFF_FFFE;
        #1 chk("mtime_lo_wr is_valid", 64'(is_valid), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                chk("mtime_lo_wr ready", 64'(ready), 64'd1);
                valid = 1'b0;
            end
`ifdef CLINT_MTIME_WRITE_EN
            exp_t  = 64'hFFFF_FFFF_FFFF_FFFE + 64'(k - 1);
            exp_ip = (k == 3) ? 2'b11 : ((k == 4) ? 2'b00 : 2'b10);
`else
            exp_t  = cyc;
            exp_ip = 2'b00;
`endif
            chk($sformatf("mtime after wr +%0d", k), mtime_out, exp_t);
            chk($sformatf("mtip after wr +%0d", k), 64'(mtip_irq), 64'(exp_ip));
        end

        // reset in the middle of an accepted write drops it
        valid = 1'b1; addr = 24'h0; wmask = 4'h1; wdata = 32'h1;
        #1 chk("midrst is_valid", 64'(is_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst ready", 64'(ready), 64'd0);
        chk("midrst rdata", 64'(rdata), 64'd0);
        chk("midrst mtime", mtime_out, 64'd0);
        chk("midrst mtip", 64'(mtip_irq), 64'd0);
        @(posedge clk); #1;
        chk("midrst msip dropped", 64'(msip_irq), 64'd0);
        valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post rst ready", 64'(ready), 64'd0);
        chk("post rst msip", 64'(msip_irq), 64'd0);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
